// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: per-pad control words, output data, synchronised and glitch-filtered
// inputs with edge interrupts, configured through a single-cycle register port.
module gpio_pad_bank #(
    parameter int                   NUM_PADS    = 8,
    parameter int                   PAD_CTL_W   = 9,
    parameter int                   FILT_W      = 4,
    parameter logic [PAD_CTL_W-1:0] PAD_CTL_RST = '0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_reg_wr,
    input  logic                          i_reg_rd,
    input  logic [5:0]                    i_reg_addr,
    input  logic [31:0]                   i_reg_wdata,
    output logic [31:0]                   o_reg_rdata,
    input  logic [NUM_PADS-1:0]           i_pad_in,
    output logic [NUM_PADS-1:0]           o_pad_out,
    output logic [NUM_PADS*PAD_CTL_W-1:0] o_pad_ctl,
    output logic                          o_irq
);

    localparam logic [5:0] ADDR_DATA_OUT    = 6'h00;
    localparam logic [5:0] ADDR_DATA_IN     = 6'h01;
    localparam logic [5:0] ADDR_IRQ_RISE_EN = 6'h02;
    localparam logic [5:0] ADDR_IRQ_FALL_EN = 6'h03;
    localparam logic [5:0] ADDR_IRQ_STATUS  = 6'h04;
    localparam logic [5:0] ADDR_FILT_THRESH = 6'h05;
    localparam int         PAD_BASE         = 8;

    logic [NUM_PADS-1:0]  r_dataOut;
    logic [NUM_PADS-1:0]  r_riseEn;
    logic [NUM_PADS-1:0]  r_fallEn;
    logic [NUM_PADS-1:0]  r_irqStatus;
    logic [FILT_W-1:0]    r_filtThresh;
    logic [PAD_CTL_W-1:0] r_padCtl [NUM_PADS];
    logic [NUM_PADS-1:0]  r_sync1;
    logic [NUM_PADS-1:0]  r_sync2;
    logic [NUM_PADS-1:0]  r_filt;
    logic [FILT_W-1:0]    r_cnt [NUM_PADS];
    logic [31:0]          r_rdata;

    logic [NUM_PADS-1:0]  w_fire;
    logic [NUM_PADS-1:0]  w_set;
    logic [NUM_PADS-1:0]  w_clr;
    logic [31:0]          w_rdMux;
    logic                 w_unused;

    assign w_unused = &{1'b0, i_reg_wdata};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dataOut    <= '0;
            r_riseEn     <= '0;
            r_fallEn     <= '0;
            r_filtThresh <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                r_padCtl[i] <= PAD_CTL_RST;
            end
        end else if (i_reg_wr) begin
            case (i_reg_addr)
                ADDR_DATA_OUT:    r_dataOut    <= i_reg_wdata[NUM_PADS-1:0];
                ADDR_IRQ_RISE_EN: r_riseEn     <= i_reg_wdata[NUM_PADS-1:0];
                ADDR_IRQ_FALL_EN: r_fallEn     <= i_reg_wdata[NUM_PADS-1:0];
                ADDR_FILT_THRESH: r_filtThresh <= i_reg_wdata[FILT_W-1:0];
                default: ;
            endcase
            for (int i = 0; i < NUM_PADS; i++) begin
                if (i_reg_addr == 6'(PAD_BASE + i)) begin
                    r_padCtl[i] <= i_reg_wdata[PAD_CTL_W-1:0];
                end
            end
        end
    end

    // A pad fires once a mismatch has persisted past the threshold; >= lets a
    // lowered threshold take effect on a counter that is already above it.
    always_comb begin
        w_fire = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            w_fire[i] = (r_sync2[i] != r_filt[i]) && (r_cnt[i] >= r_filtThresh);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= i_pad_in;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NUM_PADS; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_fire[i]) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + FILT_W'(1);
                end
            end
        end
    end

    assign w_set = (w_fire & r_sync2 & r_riseEn) | (w_fire & ~r_sync2 & r_fallEn);

    always_comb begin
        w_clr = '0;
        if (i_reg_wr && (i_reg_addr == ADDR_IRQ_STATUS)) begin
            w_clr = i_reg_wdata[NUM_PADS-1:0];
        end
    end

    // Set is applied after clear so a new event survives a simultaneous W1C.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_irqStatus <= '0;
        end else begin
            r_irqStatus <= (r_irqStatus & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_rdMux = '0;
        case (i_reg_addr)
            ADDR_DATA_OUT:    w_rdMux[NUM_PADS-1:0] = r_dataOut;
            ADDR_DATA_IN:     w_rdMux[NUM_PADS-1:0] = r_filt;
            ADDR_IRQ_RISE_EN: w_rdMux[NUM_PADS-1:0] = r_riseEn;
            ADDR_IRQ_FALL_EN: w_rdMux[NUM_PADS-1:0] = r_fallEn;
            ADDR_IRQ_STATUS:  w_rdMux[NUM_PADS-1:0] = r_irqStatus;
            ADDR_FILT_THRESH: w_rdMux[FILT_W-1:0]   = r_filtThresh;
            default: begin
                for (int i = 0; i < NUM_PADS; i++) begin
                    if (i_reg_addr == 6'(PAD_BASE + i)) begin
                        w_rdMux[PAD_CTL_W-1:0] = r_padCtl[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_reg_rd) begin
            r_rdata <= w_rdMux;
        end
    end

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_padCtl
        assign o_pad_ctl[g*PAD_CTL_W +: PAD_CTL_W] = r_padCtl[g];
    end

    assign o_pad_out   = r_dataOut;
    assign o_reg_rdata = r_rdata;
    assign o_irq       = |(r_irqStatus & (r_riseEn | r_fallEn));

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Bench for gpio_pad_bank: register reads are checked by a scoreboard monitor,
// pad/irq outputs by direct checks, all against hand-computed values.
module tb_gpio_pad_bank;

    localparam int NP = 8;
    localparam int CW = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             reg_wr;
    logic             reg_rd;
    logic [5:0]       reg_addr;
    logic [31:0]      reg_wdata;
    logic [31:0]      reg_rdata;
    logic [NP-1:0]    pad_in;
    logic [NP-1:0]    pad_out;
    logic [NP*CW-1:0] pad_ctl;
    logic             irq;

    typedef struct {
        logic [31:0] expVal;
        string       name;
    } rdExp_t;

    rdExp_t      sbQ[$];
    rdExp_t      popped;
    logic        rdPending = 1'b0;
    int          testsRun  = 0;
    int          testsFail = 0;
    logic [NP*CW-1:0] expCtl;

    gpio_pad_bank #(
        .NUM_PADS   (NP),
        .PAD_CTL_W  (CW),
        .FILT_W     (4),
        .PAD_CTL_RST(9'h0A5)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_reg_wr   (reg_wr),
        .i_reg_rd   (reg_rd),
        .i_reg_addr (reg_addr),
        .i_reg_wdata(reg_wdata),
        .o_reg_rdata(reg_rdata),
        .i_pad_in   (pad_in),
        .o_pad_out  (pad_out),
        .o_pad_ctl  (pad_ctl),
        .o_irq      (irq)
    );

    always #5 clk = ~clk;

    // rdata is valid in the cycle after a read strobe, so that cycle is the monitor's cue.
    always @(posedge clk) rdPending <= reg_rd;

    always @(negedge clk) begin
        if (rdPending) begin
            testsRun++;
            if (sbQ.size() == 0) begin
                testsFail++;
                $display("[TB] FAIL unexpected_read: got %h, no expected value queued", reg_rdata);
            end else begin
                popped = sbQ.pop_front();
                if (reg_rdata !== popped.expVal) begin
                    testsFail++;
                    $display("[TB] FAIL %s: got %h expected %h", popped.name, reg_rdata, popped.expVal);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [5:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRd,
                                 input string name);
        rdExp_t e;
        reg_wr    = wr;
        reg_rd    = rd;
        reg_addr  = addr;
        reg_wdata = wdata;
        if (rd) begin
            e.expVal = expRd;
            e.name   = name;
            sbQ.push_back(e);
        end
        tick();
        reg_wr = 1'b0;
        reg_rd = 1'b0;
    endtask

    task automatic regWrite(input logic [5:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, 1'b0, addr, wdata, 32'h0, "");
    endtask

    task automatic regRead(input logic [5:0] addr, input logic [31:0] expRd, input string name);
        applyStimulus(1'b0, 1'b1, addr, 32'h0, expRd, name);
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        pad_in    = '0;
        expCtl    = {NP{9'h0A5}};

        tick();
        tick();
        checkOutput("reset_pad_ctl", 128'(pad_ctl), 128'(expCtl));
        checkOutput("reset_pad_out", 128'(pad_out), 128'h0);
        checkOutput("reset_irq", 128'(irq), 128'h0);
        checkOutput("reset_rdata", 128'(reg_rdata), 128'h0);
        rst_n = 1'b1;
        regRead(6'h01, 32'h0, "reset_data_in");
        regRead(6'h05, 32'h0, "reset_filt_thresh");

        // Register configuration and readback.
        regWrite(6'h00, 32'hA5);
        checkOutput("pad_out_after_write", 128'(pad_out), 128'hA5);
        regWrite(6'h0B, 32'h1FF);
        expCtl[3*CW +: CW] = 9'h1FF;
        checkOutput("pad_ctl_pad3", 128'(pad_ctl), 128'(expCtl));
        regRead(6'h00, 32'hA5, "rd_data_out");
        regRead(6'h0B, 32'h1FF, "rd_pad_ctl3");
        regRead(6'h0A, 32'h0A5, "rd_pad_ctl2");
        regRead(6'h10, 32'h0, "rd_pad_ctl_out_of_range");
        regRead(6'h06, 32'h0, "rd_unmapped");
        regWrite(6'h05, 32'hFFFF_FFFF);
        regRead(6'h05, 32'h0000_000F, "rd_filt_thresh_width");
        regWrite(6'h01, 32'hFF);
        regRead(6'h01, 32'h0, "data_in_write_ignored");
        regWrite(6'h00, 32'hFFFF_FF5A);
        checkOutput("pad_out_upper_ignored", 128'(pad_out), 128'h5A);
        regRead(6'h00, 32'h5A, "rd_data_out_masked");
        applyStimulus(1'b1, 1'b1, 6'h02, 32'h3C, 32'h0, "wr_rd_same_cycle_old");
        regRead(6'h02, 32'h3C, "wr_rd_same_cycle_new");
        regWrite(6'h02, 32'h0);

        // Filter with threshold 3: a 3-cycle glitch is rejected.
        regWrite(6'h05, 32'h3);
        for (int k = 0; k < 10; k++) begin
            pad_in[0] = (k < 3);
            regRead(6'h01, 32'h0, "glitch_rejected");
        end
        // A 5-cycle pulse: f rises 5 edges after first sampling edge, falls 5 edges after it drops.
        for (int k = 0; k < 13; k++) begin
            pad_in[0] = (k < 5);
            regRead(6'h01, (k >= 6 && k <= 10) ? 32'h1 : 32'h0, "pulse_filtered");
        end
        regRead(6'h04, 32'h0, "no_status_when_disabled");

        // Rising-edge interrupt, W1C, and a fall with the fall enable off.
        regWrite(6'h05, 32'h0);
        regWrite(6'h02, 32'h1);
        pad_in[0] = 1'b1;
        tick();
        checkOutput("irq_low_edge0", 128'(irq), 128'h0);
        tick();
        checkOutput("irq_low_edge1", 128'(irq), 128'h0);
        tick();
        checkOutput("irq_high_after_rise", 128'(irq), 128'h1);
        regRead(6'h04, 32'h1, "status_after_rise");
        regWrite(6'h04, 32'h1);
        checkOutput("irq_cleared_w1c", 128'(irq), 128'h0);
        regRead(6'h04, 32'h0, "status_after_w1c");
        pad_in[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        regRead(6'h04, 32'h0, "fall_not_enabled");
        checkOutput("irq_fall_not_enabled", 128'(irq), 128'h0);

        // Fall interrupt, then disabling the enable masks irq but keeps status.
        regWrite(6'h02, 32'h0);
        regWrite(6'h03, 32'h1);
        pad_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        regRead(6'h04, 32'h0, "rise_not_enabled");
        pad_in[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        regRead(6'h04, 32'h1, "status_after_fall");
        checkOutput("irq_after_fall", 128'(irq), 128'h1);
        regWrite(6'h03, 32'h0);
        checkOutput("irq_masked_enables_off", 128'(irq), 128'h0);
        regRead(6'h04, 32'h1, "status_kept_enables_off");
        regWrite(6'h04, 32'h1);
        regRead(6'h04, 32'h0, "status_cleared");

        // Set beats clear when a W1C lands on the same edge as the event.
        regWrite(6'h02, 32'h04);
        pad_in[2] = 1'b1;
        tick();
        tick();
        regWrite(6'h04, 32'h04);
        checkOutput("irq_collision", 128'(irq), 128'h1);
        regRead(6'h04, 32'h04, "status_collision_set_wins");
        regWrite(6'h04, 32'h04);
        regRead(6'h04, 32'h0, "status_after_collision_clear");

        // Reset in the middle of a filter count restarts the full latency.
        pad_in = '0;
        regWrite(6'h02, 32'h02);
        regWrite(6'h05, 32'h7);
        for (int k = 0; k < 4; k++) tick();
        pad_in[1] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("midreset_pad_ctl", 128'(pad_ctl), 128'({NP{9'h0A5}}));
        checkOutput("midreset_pad_out", 128'(pad_out), 128'h0);
        checkOutput("midreset_irq", 128'(irq), 128'h0);
        checkOutput("midreset_rdata", 128'(reg_rdata), 128'h0);
        rst_n = 1'b1;
        regWrite(6'h05, 32'h7);
        for (int k = 1; k <= 10; k++) begin
            regRead(6'h01, (k >= 10) ? 32'h2 : 32'h0, "midreset_latency");
        end
        regRead(6'h04, 32'h0, "midreset_status_enables_cleared");
        checkOutput("midreset_irq_final", 128'(irq), 128'h0);

        tick();
        tick();
        checkOutput("scoreboard_drained", 128'(sbQ.size()), 128'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
